// File: rtl/seq_control_if.sv
// seq_control_if: sequencer <-> program memory / register file / ALU bundle
interface seq_control_if;
    logic        run;
    logic [15:0] instr;
    logic        alu_zero;
    logic [7:0]  pc;
    logic [3:0]  address_A;
    logic [3:0]  address_B;
    logic [3:0]  address_D;
    logic        enable;
    logic [7:0]  imm;
    logic        imm_sel;
    logic [2:0]  alu_op;
    logic        halted;

    modport master (
        input  run, instr, alu_zero,
        output pc, address_A, address_B, address_D, enable, imm, imm_sel, alu_op, halted
    );

    modport slave (
        output run, instr, alu_zero,
        input  pc, address_A, address_B, address_D, enable, imm, imm_sel, alu_op, halted
    );
endinterface

// File: rtl/seq_control.sv
// seq_control: 4-cycle fetch/decode/execute/writeback sequencer, state on falling nclk
module seq_control (
    input logic          nclk,
    input logic          nreset,
    seq_control_if.master bus
);
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  pc_q, pc_d;
    logic        z_q, z_d;
    logic        halted_q, halted_d;
    logic        enable_q, enable_d;
    logic [3:0]  op;
    logic        writes, sets_z, take;

    assign op     = ir_q[15:12];
    assign writes = op >= 4'h1 && op <= 4'h7;
    assign sets_z = (op >= 4'h1 && op <= 4'h5) || op == 4'hB;
    assign take   = op == 4'h8 || (op == 4'h9 && z_q) || (op == 4'hA && !z_q);

    // Operand and ALU control decode straight from IR, stable for the whole instruction
    always_comb begin
        bus.address_D = ir_q[11:8];
        bus.address_A = ir_q[7:4];
        bus.address_B = ir_q[3:0];
        bus.imm       = ir_q[7:0];
        bus.imm_sel   = op == 4'h6;
        bus.alu_op    = (op == 4'h2 || op == 4'hB) ? 3'd1 :
                        op == 4'h3 ? 3'd2 :
                        op == 4'h4 ? 3'd3 :
                        op == 4'h5 ? 3'd4 :
                        op == 4'h7 ? 3'd5 : 3'd0;
        bus.pc        = pc_q;
        bus.enable    = enable_q;
        bus.halted    = halted_q;
    end

    // Next-state logic; the halt flag freezes everything until reset
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        z_d      = z_q;
        halted_d = halted_q;
        enable_d = 1'b0;
        if (!halted_q) begin
            case (state_q)
                FETCH: begin
                    if (bus.run) begin
                        ir_d    = bus.instr;
                        state_d = DECODE;
                    end
                end
                DECODE: state_d = EXECUTE;
                EXECUTE: begin
                    state_d  = WRITEBACK;
                    z_d      = sets_z ? bus.alu_zero : z_q;
                    enable_d = writes;
                end
                default: begin
                    state_d  = FETCH;
                    halted_d = op == 4'hF;
                    pc_d     = op == 4'hF ? pc_q : take ? ir_q[7:0] : pc_q + 8'd1;
                end
            endcase
        end
    end

    // Registered state; reset overrides every state and kills a pending write
    always_ff @(negedge nclk) begin
        if (!nreset) begin
            state_q  <= FETCH;
            ir_q     <= 16'h0000;
            pc_q     <= 8'h00;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            z_q      <= z_d;
            halted_q <= halted_d;
            enable_q <= enable_d;
        end
    end
endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: instruction 16 bits, PC 8 bits, register address 4 bits, immediate 8 bits.
REQ-002 nclk  input  1  single clock; all state SHALL update on the falling edge of nclk only.
REQ-003 nreset  input  1  synchronous active-low reset, sampled on the falling edge of nclk.
REQ-004 run  input  1  1 = sequencer advances; 0 = hold in FETCH.
REQ-005 instr  input  16  instruction word from program memory at address pc; [15:12] opcode, [11:8] D, [7:4] A, [3:0] B, [7:0] imm8.
REQ-006 alu_zero  input  1  ALU result-is-zero indication for the current address_A/address_B operands and alu_op.
REQ-007 pc  output  8  program counter; program memory address.
REQ-008 address_A, address_B, address_D  output  4 each  register-file read and write addresses.
REQ-009 enable  output  1  register-file write enable.
REQ-010 imm  output  8  immediate operand, driven from IR[7:0].
REQ-011 imm_sel  output  1  1 = data_in mux selects imm; 0 = selects ALU result.
REQ-012 alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A.
REQ-013 halted  output  1  1 after a HALT instruction retires.

Function
REQ-014 The FSM SHALL have the states FETCH, DECODE, EXECUTE, WRITEBACK and HALT, with a 2-bit encoding for the four run states plus a separate halt flag.
REQ-015 FETCH: when run=1, IR SHALL capture instr and the next state SHALL be DECODE; when run=0, the FSM SHALL stay in FETCH and IR SHALL hold.
REQ-016 The sequence DECODE -> EXECUTE -> WRITEBACK -> FETCH SHALL be unconditional, giving exactly 4 cycles per instruction.
REQ-017 address_A, address_B, address_D, imm, imm_sel and alu_op SHALL be combinational decodes of IR and SHALL be stable from DECODE through WRITEBACK.
REQ-018 Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 LDI (rD=imm8); 7 MOV (rD=rA, PASS_A); 8 JMP imm8; 9 JZ imm8; A JNZ imm8; B CMP (SUB, no write); F HALT; C, D and E SHALL behave as NOP.
REQ-019 enable SHALL be 1 only during WRITEBACK and only for opcodes 1-7.
REQ-020 imm_sel SHALL be 1 only for LDI.
REQ-021 The Z flag register SHALL load alu_zero at the end of EXECUTE for opcodes 1-5 and B; all other opcodes SHALL leave Z unchanged.
REQ-022 PC update at the end of WRITEBACK: JMP SHALL load pc=imm8.
REQ-023 PC update at the end of WRITEBACK: JZ SHALL load pc=imm8 if Z=1, else pc+1.
REQ-024 PC update at the end of WRITEBACK: JNZ SHALL load pc=imm8 if Z=0, else pc+1.
REQ-025 PC update at the end of WRITEBACK: all other opcodes SHALL load pc+1, modulo 256 (pc 0xFF wraps to 0x00).
REQ-026 Z SHALL be evaluated after any same-instruction update; in practice jump opcodes never update Z, so JZ and JNZ SHALL use the value left by the prior flag-setting instruction.
REQ-027 HALT at WRITEBACK: pc SHALL be unchanged, halted SHALL be set to 1, and the FSM SHALL enter HALT.
REQ-028 HALT is terminal: only nreset=0 SHALL leave it; enable=0 throughout; run is ignored.
REQ-029 run=0 SHALL be honoured only in FETCH; an instruction already past FETCH SHALL complete.

Reset
REQ-030 When nreset=0 at a falling edge of nclk, the next state SHALL be pc=0x00, IR=0x0000, Z=0, halted=0, state=FETCH.
REQ-031 During and after reset, enable SHALL be 0; with IR=0 the decoded outputs SHALL be address_A=address_B=address_D=0, imm=0x00, imm_sel=0, alu_op=ADD.
REQ-032 Reset SHALL take priority over run and over every FSM state, including mid-instruction and HALT; a write in progress SHALL be suppressed (enable=0 on the reset edge's following cycle).

Verification
REQ-033 After reset, run=1 and instr=0x6305 (LDI r3,5): enable=1 only in cycle 4 with address_D=3, imm_sel=1, imm=0x05; pc goes 0->1 after cycle 4.
REQ-034 instr=0x1312 (ADD r3,r1,r2), alu_zero=0: alu_op=ADD, address_A=1, address_B=2, address_D=3, enable pulses once, Z=0, pc increments.
REQ-035 CMP (0xB012) with alu_zero=1, then JZ 0x40 (0x9040): pc=0x40 after the JZ WRITEBACK; repeat with alu_zero=0 -> pc=previous+1; JNZ gives the opposite outcome.
REQ-036 pc=0xFF executing NOP -> pc=0x00; JMP 0xFF (0x80FF) -> pc=0xFF.
REQ-037 HALT (0xF000) -> halted=1, pc frozen, enable=0 for 20 cycles with run toggling; nreset=0 -> pc=0, halted=0, FETCH.
REQ-038 run=0 held for 10 cycles in FETCH -> pc and IR unchanged; nreset=0 asserted during the EXECUTE of an ADD -> no enable pulse, pc=0 on the next cycle.
